// File: rtl/mem_responder_256b_pkg.sv
// mem_responder_256b_pkg: op3 codes, FSM states and opcode decode shared by the memory responder.
`default_nettype none

package mem_responder_256b_pkg;

    localparam logic [5:0] OP_LD    = 6'h00;
    localparam logic [5:0] OP_LDUB  = 6'h01;
    localparam logic [5:0] OP_LDUH  = 6'h02;
    localparam logic [5:0] OP_ST    = 6'h04;
    localparam logic [5:0] OP_STB   = 6'h05;
    localparam logic [5:0] OP_STH   = 6'h06;
    localparam logic [5:0] OP_FETCH = 6'h08;
    localparam logic [5:0] OP_LDSB  = 6'h09;
    localparam logic [5:0] OP_LDSH  = 6'h0A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  legal;
        logic  store;
        logic  sext;
        size_t size;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d.legal = 1'b1;
        d.store = 1'b0;
        d.sext  = 1'b0;
        d.size  = SZ_WORD;
        case (op)
            OP_LD, OP_FETCH: d.size = SZ_WORD;
            OP_LDUB:         d.size = SZ_BYTE;
            OP_LDUH:         d.size = SZ_HALF;
            OP_LDSB:         begin d.size = SZ_BYTE; d.sext = 1'b1; end
            OP_LDSH:         begin d.size = SZ_HALF; d.sext = 1'b1; end
            OP_ST:           begin d.size = SZ_WORD; d.store = 1'b1; end
            OP_STB:          begin d.size = SZ_BYTE; d.store = 1'b1; end
            OP_STH:          begin d.size = SZ_HALF; d.store = 1'b1; end
            default:         d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_HALF: return a[0];
            SZ_WORD: return |a;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_256b_array.sv
// mem_responder_256b_array: 256x8 byte store, registered 1/2/4-byte write, combinational 4-byte read.
`default_nettype none

module mem_responder_256b_array (
    input  logic        clk,
    input  logic        i_we,
    input  logic [3:0]  i_be,
    input  logic [7:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0] r_mem [256];

    // Lane i (bit 3-i of i_be, bits 31-8i of data) maps to byte i_addr+i: big-endian.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[3-i]) begin
                    r_mem[i_addr + 8'(i)] <= i_wdata[31-8*i -: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign o_rdata[31-8*g -: 8] = r_mem[i_addr + 8'(g)];
    end

endmodule

`default_nettype wire

// File: rtl/mem_responder_256b.sv
// mem_responder_256b: MFA/MFC memory responder with op3 decode, alignment check and wait states.
`default_nettype none

module mem_responder_256b
    import mem_responder_256b_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MFA,
    input  logic [5:0]  OP,
    input  logic [7:0]  Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        MAE,
    output logic        MERR
);

    localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] c_WAIT = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_op;
    logic [7:0]       r_addr;
    logic [31:0]      r_data;

    logic [5:0]  w_op;
    logic [7:0]  w_addr;
    logic [31:0] w_data;
    dec_t        w_dec;
    logic        w_misal;
    logic        w_enter_done;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [31:0] w_load;

    // With zero wait states the access completes on the sampling edge, so use live inputs then.
    assign w_op    = (r_state == S_IDLE) ? OP      : r_op;
    assign w_addr  = (r_state == S_IDLE) ? Address : r_addr;
    assign w_data  = (r_state == S_IDLE) ? DataIn  : r_data;
    assign w_dec   = decode_op(w_op);
    assign w_misal = is_misaligned(w_dec.size, w_addr[1:0]);

    assign w_enter_done = MFA &&
        (((r_state == S_IDLE) && w_dec.legal && !w_misal && (WAIT_STATES == 0)) ||
         ((r_state == S_BUSY) && (r_cnt == c_ONE)));
    assign w_we = Clr && w_enter_done && w_dec.store;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = w_data;
        w_load  = w_rdata;
        case (w_dec.size)
            SZ_BYTE: begin
                w_be    = 4'b1000;
                w_wdata = {w_data[7:0], 24'h0};
                w_load  = {{24{w_dec.sext & w_rdata[31]}}, w_rdata[31:24]};
            end
            SZ_HALF: begin
                w_be    = 4'b1100;
                w_wdata = {w_data[15:0], 16'h0};
                w_load  = {{16{w_dec.sext & w_rdata[31]}}, w_rdata[31:16]};
            end
            default: ;
        endcase
    end

    mem_responder_256b_array u_array (
        .clk     (Clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            DataOut <= '0;
            MFC     <= 1'b0;
            MAE     <= 1'b0;
            MERR    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    MFC  <= 1'b0;
                    MAE  <= 1'b0;
                    MERR <= 1'b0;
                    if (MFA) begin
                        r_op   <= OP;
                        r_addr <= Address;
                        r_data <= DataIn;
                        if (!w_dec.legal) begin
                            r_state <= S_FAULT;
                            MERR    <= 1'b1;
                        end else if (w_misal) begin
                            r_state <= S_FAULT;
                            MAE     <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state <= S_DONE;
                            MFC     <= 1'b1;
                            if (!w_dec.store) DataOut <= w_load;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= c_WAIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (!MFA) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_ONE) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        MFC     <= 1'b1;
                        if (!w_dec.store) DataOut <= w_load;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_DONE: begin
                    if (!MFA) begin
                        r_state <= S_IDLE;
                        MFC     <= 1'b0;
                    end
                end
                S_FAULT: begin
                    if (!MFA) begin
                        r_state <= S_IDLE;
                        MAE     <= 1'b0;
                        MERR    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
